// File: rtl/fcpu_pkg.sv
// rtl/fcpu_pkg.sv - shared types and UART defaults; UART_TX_PARITY_EN adds the PARITY state
package fcpu_pkg;

  localparam int UART_CLK_HZ = 100_000_000;
  localparam int UART_BAUD   = 115_200;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with extra-MSB pointers, head read from storage registers
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("byte_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  // Same slot with differing wrap bits means the writer is a full lap ahead.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-fed UART transmitter, 8N1 or 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import fcpu_pkg::*;
#(
  parameter int CLK_HZ     = UART_CLK_HZ,
  parameter int BAUD       = UART_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       i_ready,
  output logic       txd,
  output logic       busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: CLK_HZ / BAUD must be at least 2");
  end

  uart_tx_state_t state;
  uart_tx_state_t state_next;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     sreg;
  logic           txd_q;
  logic           txd_next;
  logic           pop;
  logic           bit_done;
  logic [7:0]     fifo_rd_data;
  logic           fifo_full;
  logic           fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic           par_q;
`endif

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (i_valid),
    .wr_data(i_data),
    .pop    (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_done = (baud_cnt == CW'(DIV - 1));
  assign i_ready  = !fifo_full;
  assign txd      = txd_q;
  assign busy     = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    txd_next   = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        txd_next = sreg[0];
        if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_next = par_q;
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        txd_next = 1'b1;
        // Chain straight into the next start bit so bursts leave no idle gap.
        if (bit_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // txd is re-registered from the current state, so it trails the FSM by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      txd_q <= txd_next;

      if (state == IDLE || bit_done) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + CW'(1);

      if (pop) begin
        sreg  <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
        par_q <= even_parity(fifo_rd_data);
`endif
      end else if (state == DATA && bit_done) begin
        sreg <= {1'b0, sreg[7:1]};
      end

      if (state == START)                bit_cnt <= '0;
      else if (state == DATA && bit_done) bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed scoreboard bench for uart_tx (DIV=8); define UART_TX_PARITY_EN for 8E1
module tb_uart_tx;

  localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic       txd;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(
    .CLK_HZ    (8),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk1("idle_reached", busy, 1'b0);
  endtask

  // Line decoder: samples mid-bit and checks each frame against the scoreboard.
  logic             rx_active = 1'b0;
  int               rx_cnt = 0;
  logic [NBITS-1:0] rx_bits = '0;
  logic [NBITS-1:0] rx_ef = '0;
  logic [7:0]       rx_exp = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        rx_bits[rx_cnt / DIV] = txd;
        if (rx_cnt / DIV == NBITS - 1) begin
          rx_active = 1'b0;
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rx_extra_frame observed %0h expected no frame", rx_bits);
          end else begin
            rx_exp = exp_q.pop_front();
            for (int k = 0; k < NBITS; k++) rx_ef[k] = frame_bit(rx_exp, k);
            chk("rx_frame", 32'(rx_bits), 32'(rx_ef));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0;
    int         idx;
    int         n;
    int         f0;
    int         acc[8];
    logic [7:0] burst[8];

    repeat (3) @(negedge clk);
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", i_ready, 1'b1);
    rst = 1'b0;

    repeat (1000) begin
      @(negedge clk);
      chk1("idle_txd", txd, 1'b1);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_ready", i_ready, 1'b1);
    end

    // Single byte 0x55: latency, bit pattern, busy release.
    chk1("ready_55", i_ready, 1'b1);
    i_data = 8'h55; i_valid = 1'b1; exp_q.push_back(8'h55); t0 = cyc + 1;
    @(negedge clk);
    i_valid = 1'b0;
    chk1("lat_t0_txd", txd, 1'b1);
    @(negedge clk);
    chk1("lat_t1_txd", txd, 1'b1);
    chk1("lat_t1_busy", busy, 1'b1);
    wait_cyc(t0 + 2);
    chk1("lat_t2_txd_fall", txd, 1'b0);
    for (int k = 0; k < NBITS; k++) begin
      wait_cyc(t0 + 2 + k * DIV + DIV / 2);
      chk1("frame55_bit", txd, frame_bit(8'h55, k));
    end
    wait_cyc(t0 + FRAME);
    chk1("busy_before_end", busy, 1'b1);
    wait_cyc(t0 + 2 + FRAME);
    chk1("busy_after_end", busy, 1'b0);
    chk("sb_55_empty", 32'(exp_q.size()), 32'd0);

    // 0x01 then 0x03: parity 1 then 0, back-to-back.
    start_q.delete();
    f0 = frames;
    chk1("ready_01", i_ready, 1'b1);
    i_data = 8'h01; i_valid = 1'b1; exp_q.push_back(8'h01);
    @(negedge clk);
    chk1("ready_03", i_ready, 1'b1);
    i_data = 8'h03; exp_q.push_back(8'h03);
    @(negedge clk);
    i_valid = 1'b0;
    wait_idle(4 * FRAME);
    chk("pair_frames", 32'(frames - f0), 32'd2);
    chk("pair_starts", 32'(start_q.size()), 32'd2);
    if (start_q.size() >= 2) chk("pair_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));
    chk("sb_pair_empty", 32'(exp_q.size()), 32'd0);

    // Burst 0xA0..0xA7 with i_valid held high.
    start_q.delete();
    for (int i = 0; i < 8; i++) begin
      burst[i] = 8'hA0 + 8'(i);
      acc[i]   = 0;
    end
    idx = 0; n = 0;
    i_data = burst[0]; i_valid = 1'b1;
    while (idx < 8 && n < 2000) begin
      if (i_ready) begin
        exp_q.push_back(i_data);
        acc[idx] = cyc + 1;
        idx++;
      end
      @(negedge clk);
      n++;
      if (idx < 8) i_data = burst[idx];
      else         i_valid = 1'b0;
    end
    i_valid = 1'b0;
    chk("burst_accepted", 32'(idx), 32'd8);
    for (int i = 1; i < 5; i++) chk("burst_consec", 32'(acc[i] - acc[i-1]), 32'd1);
    chk1("burst_stall", (acc[5] - acc[4]) > 1, 1'b1);
    wait_idle(10 * FRAME);
    chk("sb_burst_empty", 32'(exp_q.size()), 32'd0);
    chk("burst_frames", 32'(start_q.size()), 32'd8);
    if (start_q.size() == 8) begin
      for (int j = 1; j < 8; j++) chk("burst_gap", 32'(start_q[j] - start_q[j-1]), 32'(FRAME));
      for (int k = 5; k < 8; k++) chk("accept_after_pop", 32'(acc[k]), 32'(start_q[k-4]));
    end

    // Reset during DATA bit 3 of 0xFF with two bytes queued.
    i_data = 8'hFF; i_valid = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    i_data = 8'h11;
    @(negedge clk);
    i_data = 8'h22;
    @(negedge clk);
    i_valid = 1'b0;
    wait_cyc(t0 + 2 + 4 * DIV + DIV / 2);
    chk1("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_txd", txd, 1'b1);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_ready", i_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = frames;
    start_q.delete();
    repeat (200) begin
      @(negedge clk);
      chk1("post_rst_txd", txd, 1'b1);
      chk1("post_rst_busy", busy, 1'b0);
    end
    chk("post_rst_frames", 32'(frames - f0), 32'd0);
    chk("post_rst_starts", 32'(start_q.size()), 32'd0);

    // Reset during the start bit: txd must return high before the next clock edge.
    i_data = 8'h00; i_valid = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    i_valid = 1'b0;
    wait_cyc(t0 + 2 + DIV / 2);
    chk1("start_low", txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("async_start_txd", txd, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    chk1("final_txd", txd, 1'b1);
    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
